// File: rtl/sctag_vuad_diag_rsp.sv
// sctag_vuad_diag_rsp
//
// Response side of the VUAD diagnostic read pipeline. The C8 diag read data
// and requesting thread id are held in a stage register. One cycle later they
// are joined with the C9 parity syndrome into a single entry, which is pushed
// into a 2-entry response FIFO. The head entry goes back to the return path
// under a valid/ack handshake. Diagnostic reads that carry a parity error also
// update a first-error log and a saturating error counter.
//
// Ports
//   rclk, arst            clock, asynchronous active-high reset
//   diag_rd_vld_c8        diag read in C8 this cycle
//   diag_rd_tid_c8        requesting thread id (with diag_rd_vld_c8)
//   vuad_dp_diag_data_c7  diag read data; this is C8 data despite the name
//   vuad_syndrome_c9      parity syndrome {valid, dirty, used, alloc}
//   rsp_ack               consumer accepts the head entry
//   err_clr               clears the error log, error counter and drop_ovf
//   rsp_vld/data/tid/perr head entry of the response FIFO
//   diag_rd_stall         advisory to arbctl: stop issuing diag reads
//   err_vld/syn/tid       first-error log
//   err_multi             another error arrived after the first was logged
//   err_cnt               saturating count of erroring entries
//   drop_ovf              an entry was discarded because the FIFO was full
module sctag_vuad_diag_rsp #(
  parameter int CNTW = 8
) (
  input  logic            rclk,
  input  logic            arst,
  input  logic            diag_rd_vld_c8,
  input  logic [4:0]      diag_rd_tid_c8,
  input  logic [25:0]     vuad_dp_diag_data_c7,
  input  logic [3:0]      vuad_syndrome_c9,
  input  logic            rsp_ack,
  input  logic            err_clr,
  output logic            rsp_vld,
  output logic [25:0]     rsp_data,
  output logic [4:0]      rsp_tid,
  output logic [3:0]      rsp_perr,
  output logic            diag_rd_stall,
  output logic            err_vld,
  output logic [3:0]      err_syn,
  output logic [4:0]      err_tid,
  output logic            err_multi,
  output logic [CNTW-1:0] err_cnt,
  output logic            drop_ovf
);

  localparam int DEPTH = 2;
  localparam int EW    = 26 + 5 + 4;

  // C8 stage
  logic [25:0] stage_data_q, stage_data_d;
  logic [4:0]  stage_tid_q, stage_tid_d;
  logic        pend_q, pend_d;

  // FIFO
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;

  // Error log
  logic            err_vld_q, err_vld_d;
  logic [3:0]      err_syn_q, err_syn_d;
  logic [4:0]      err_tid_q, err_tid_d;
  logic            err_multi_q, err_multi_d;
  logic [CNTW-1:0] err_cnt_q, err_cnt_d;
  logic            drop_ovf_q, drop_ovf_d;

  logic          push, pop, full, push_ok, drop, err_hit;
  logic [EW-1:0] entry;
  logic [EW-1:0] head;

  always_comb begin
    push    = pend_q;
    pop     = (count_q != 2'd0) && rsp_ack;
    full    = (count_q == 2'd2);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;
    // Dropped entries are still seen by the error log.
    err_hit = push && (vuad_syndrome_c9 != 4'h0);
    entry   = {stage_data_q, stage_tid_q, vuad_syndrome_c9};
    head    = mem_q[rd_ptr_q];
  end

  // Stage register: its old contents are consumed by this cycle's push
  // before being overwritten, so back-to-back reads are safe.
  always_comb begin
    stage_data_d = stage_data_q;
    stage_tid_d  = stage_tid_q;
    pend_d       = diag_rd_vld_c8;
    if (diag_rd_vld_c8) begin
      stage_data_d = vuad_dp_diag_data_c7;
      stage_tid_d  = diag_rd_tid_c8;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = entry;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    err_vld_d   = err_vld_q & ~err_clr;
    err_syn_d   = err_syn_q;
    err_tid_d   = err_tid_q;
    err_multi_d = err_multi_q & ~err_clr;
    err_cnt_d   = err_clr ? '0 : err_cnt_q;
    drop_ovf_d  = (drop_ovf_q & ~err_clr) | drop;
    if (err_hit) begin
      // With err_clr in the same cycle the new error starts a fresh log.
      if (err_clr || !err_vld_q) begin
        err_vld_d = 1'b1;
        err_syn_d = vuad_syndrome_c9;
        err_tid_d = stage_tid_q;
      end else begin
        err_multi_d = 1'b1;
      end
      if (err_clr) begin
        err_cnt_d = {{(CNTW-1){1'b0}}, 1'b1};
      end else if (err_cnt_q != {CNTW{1'b1}}) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      stage_data_q <= '0;
      stage_tid_q  <= '0;
      pend_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      err_vld_q    <= 1'b0;
      err_syn_q    <= '0;
      err_tid_q    <= '0;
      err_multi_q  <= 1'b0;
      err_cnt_q    <= '0;
      drop_ovf_q   <= 1'b0;
    end else begin
      stage_data_q <= stage_data_d;
      stage_tid_q  <= stage_tid_d;
      pend_q       <= pend_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_vld_q    <= err_vld_d;
      err_syn_q    <= err_syn_d;
      err_tid_q    <= err_tid_d;
      err_multi_q  <= err_multi_d;
      err_cnt_q    <= err_cnt_d;
      drop_ovf_q   <= drop_ovf_d;
    end
  end

  assign rsp_vld       = (count_q != 2'd0);
  assign rsp_data      = head[EW-1:9];
  assign rsp_tid       = head[8:4];
  assign rsp_perr      = head[3:0];
  // Counts the entry still in C9 so arbctl backs off before a drop can occur.
  assign diag_rd_stall = ({1'b0, count_q} + {2'b00, pend_q}) >= 3'd2;
  assign err_vld       = err_vld_q;
  assign err_syn       = err_syn_q;
  assign err_tid       = err_tid_q;
  assign err_multi     = err_multi_q;
  assign err_cnt       = err_cnt_q;
  assign drop_ovf      = drop_ovf_q;

endmodule

// File: tb/tb_sctag_vuad_diag_rsp.sv
module tb_sctag_vuad_diag_rsp;

  logic        rclk = 1'b0;
  logic        arst;
  logic        diag_rd_vld_c8;
  logic [4:0]  diag_rd_tid_c8;
  logic [25:0] vuad_dp_diag_data_c7;
  logic [3:0]  vuad_syndrome_c9;
  logic        rsp_ack;
  logic        err_clr;
  logic        rsp_vld;
  logic [25:0] rsp_data;
  logic [4:0]  rsp_tid;
  logic [3:0]  rsp_perr;
  logic        diag_rd_stall;
  logic        err_vld;
  logic [3:0]  err_syn;
  logic [4:0]  err_tid;
  logic        err_multi;
  logic [7:0]  err_cnt;
  logic        drop_ovf;

  sctag_vuad_diag_rsp #(.CNTW(8)) dut (
    .rclk                 (rclk),
    .arst                 (arst),
    .diag_rd_vld_c8       (diag_rd_vld_c8),
    .diag_rd_tid_c8       (diag_rd_tid_c8),
    .vuad_dp_diag_data_c7 (vuad_dp_diag_data_c7),
    .vuad_syndrome_c9     (vuad_syndrome_c9),
    .rsp_ack              (rsp_ack),
    .err_clr              (err_clr),
    .rsp_vld              (rsp_vld),
    .rsp_data             (rsp_data),
    .rsp_tid              (rsp_tid),
    .rsp_perr             (rsp_perr),
    .diag_rd_stall        (diag_rd_stall),
    .err_vld              (err_vld),
    .err_syn              (err_syn),
    .err_tid              (err_tid),
    .err_multi            (err_multi),
    .err_cnt              (err_cnt),
    .drop_ovf             (drop_ovf)
  );

  always #5 rclk = ~rclk;

  // Inputs for one cycle, then the outputs expected after that cycle's edge.
  typedef struct packed {
    logic        vld;
    logic [4:0]  tid;
    logic [25:0] data;
    logic [3:0]  syn;
    logic        ack;
    logic        clr;
    logic        e_vld;
    logic [25:0] e_data;
    logic [4:0]  e_tid;
    logic [3:0]  e_perr;
    logic        e_stall;
    logic        e_errv;
    logic [3:0]  e_esyn;
    logic [4:0]  e_etid;
    logic        e_multi;
    logic [7:0]  e_cnt;
    logic        e_drop;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  vec_t tbl [20];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s (vector %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    diag_rd_vld_c8       = v.vld;
    diag_rd_tid_c8       = v.tid;
    vuad_dp_diag_data_c7 = v.data;
    vuad_syndrome_c9     = v.syn;
    rsp_ack              = v.ack;
    err_clr              = v.clr;
  endtask

  task automatic run_vec(input vec_t v, input int idx, input bit do_chk);
    drive(v);
    @(posedge rclk);
    #1;
    if (do_chk) begin
      n_vec++;
      chk("rsp_vld", idx, 32'(rsp_vld), 32'(v.e_vld));
      // Head payload is only meaningful while rsp_vld is high.
      if (v.e_vld) begin
        chk("rsp_data", idx, 32'(rsp_data), 32'(v.e_data));
        chk("rsp_tid",  idx, 32'(rsp_tid),  32'(v.e_tid));
        chk("rsp_perr", idx, 32'(rsp_perr), 32'(v.e_perr));
      end
      chk("diag_rd_stall", idx, 32'(diag_rd_stall), 32'(v.e_stall));
      chk("err_vld",   idx, 32'(err_vld),   32'(v.e_errv));
      chk("err_syn",   idx, 32'(err_syn),   32'(v.e_esyn));
      chk("err_tid",   idx, 32'(err_tid),   32'(v.e_etid));
      chk("err_multi", idx, 32'(err_multi), 32'(v.e_multi));
      chk("err_cnt",   idx, 32'(err_cnt),   32'(v.e_cnt));
      chk("drop_ovf",  idx, 32'(drop_ovf),  32'(v.e_drop));
    end
  endtask

  task automatic chk_all_zero(input string name, input int idx);
    n_vec++;
    chk({name, ".rsp_vld"},   idx, 32'(rsp_vld),   0);
    chk({name, ".rsp_data"},  idx, 32'(rsp_data),  0);
    chk({name, ".rsp_tid"},   idx, 32'(rsp_tid),   0);
    chk({name, ".rsp_perr"},  idx, 32'(rsp_perr),  0);
    chk({name, ".stall"},     idx, 32'(diag_rd_stall), 0);
    chk({name, ".err_vld"},   idx, 32'(err_vld),   0);
    chk({name, ".err_syn"},   idx, 32'(err_syn),   0);
    chk({name, ".err_tid"},   idx, 32'(err_tid),   0);
    chk({name, ".err_multi"}, idx, 32'(err_multi), 0);
    chk({name, ".err_cnt"},   idx, 32'(err_cnt),   0);
    chk({name, ".drop_ovf"},  idx, 32'(drop_ovf),  0);
  endtask

  initial begin
    vec_t v;

    // vld tid data syn ack clr | rvld rdata rtid rperr stall | ev esyn etid multi cnt drop
    // clean read
    tbl[0]  = '{1'b1, 5'd3, 26'h2AA_AAAA, 4'h0, 1'b0, 1'b0,  1'b0, 26'h0, 5'd0, 4'h0, 1'b0,  1'b0, 4'h0, 5'd0, 1'b0, 8'd0, 1'b0};
    tbl[1]  = '{1'b0, 5'd0, 26'h0,       4'h0, 1'b0, 1'b0,  1'b1, 26'h2AA_AAAA, 5'd3, 4'h0, 1'b0,  1'b0, 4'h0, 5'd0, 1'b0, 8'd0, 1'b0};
    tbl[2]  = '{1'b0, 5'd0, 26'h0,       4'h0, 1'b1, 1'b0,  1'b0, 26'h0, 5'd0, 4'h0, 1'b0,  1'b0, 4'h0, 5'd0, 1'b0, 8'd0, 1'b0};
    // first error then second error
    tbl[3]  = '{1'b1, 5'd7, 26'h000_0123, 4'h0, 1'b0, 1'b0,  1'b0, 26'h0, 5'd0, 4'h0, 1'b0,  1'b0, 4'h0, 5'd0, 1'b0, 8'd0, 1'b0};
    tbl[4]  = '{1'b0, 5'd0, 26'h0,       4'h8, 1'b0, 1'b0,  1'b1, 26'h000_0123, 5'd7, 4'h8, 1'b0,  1'b1, 4'h8, 5'd7, 1'b0, 8'd1, 1'b0};
    tbl[5]  = '{1'b1, 5'd9, 26'h3FF_FFFF, 4'h0, 1'b1, 1'b0,  1'b0, 26'h0, 5'd0, 4'h0, 1'b0,  1'b1, 4'h8, 5'd7, 1'b0, 8'd1, 1'b0};
    tbl[6]  = '{1'b0, 5'd0, 26'h0,       4'h1, 1'b0, 1'b0,  1'b1, 26'h3FF_FFFF, 5'd9, 4'h1, 1'b0,  1'b1, 4'h8, 5'd7, 1'b1, 8'd2, 1'b0};
    tbl[7]  = '{1'b0, 5'd0, 26'h0,       4'h0, 1'b1, 1'b0,  1'b0, 26'h0, 5'd0, 4'h0, 1'b0,  1'b1, 4'h8, 5'd7, 1'b1, 8'd2, 1'b0};
    // overflow: three back-to-back reads, third (erroring) entry dropped
    tbl[8]  = '{1'b1, 5'd1, 26'h1,       4'h0, 1'b0, 1'b0,  1'b0, 26'h0, 5'd0, 4'h0, 1'b0,  1'b1, 4'h8, 5'd7, 1'b1, 8'd2, 1'b0};
    tbl[9]  = '{1'b1, 5'd2, 26'h2,       4'h0, 1'b0, 1'b0,  1'b1, 26'h1, 5'd1, 4'h0, 1'b1,  1'b1, 4'h8, 5'd7, 1'b1, 8'd2, 1'b0};
    tbl[10] = '{1'b1, 5'd3, 26'h3,       4'h0, 1'b0, 1'b0,  1'b1, 26'h1, 5'd1, 4'h0, 1'b1,  1'b1, 4'h8, 5'd7, 1'b1, 8'd2, 1'b0};
    tbl[11] = '{1'b0, 5'd0, 26'h0,       4'h4, 1'b0, 1'b0,  1'b1, 26'h1, 5'd1, 4'h0, 1'b1,  1'b1, 4'h8, 5'd7, 1'b1, 8'd3, 1'b1};
    tbl[12] = '{1'b0, 5'd0, 26'h0,       4'h0, 1'b1, 1'b0,  1'b1, 26'h2, 5'd2, 4'h0, 1'b0,  1'b1, 4'h8, 5'd7, 1'b1, 8'd3, 1'b1};
    tbl[13] = '{1'b0, 5'd0, 26'h0,       4'h0, 1'b1, 1'b0,  1'b0, 26'h0, 5'd0, 4'h0, 1'b0,  1'b1, 4'h8, 5'd7, 1'b1, 8'd3, 1'b1};
    // err_clr (keeps syn/tid), then full push+pop without drop
    tbl[14] = '{1'b1, 5'd4, 26'h4,       4'h0, 1'b0, 1'b1,  1'b0, 26'h0, 5'd0, 4'h0, 1'b0,  1'b0, 4'h8, 5'd7, 1'b0, 8'd0, 1'b0};
    tbl[15] = '{1'b1, 5'd5, 26'h5,       4'h0, 1'b0, 1'b0,  1'b1, 26'h4, 5'd4, 4'h0, 1'b1,  1'b0, 4'h8, 5'd7, 1'b0, 8'd0, 1'b0};
    tbl[16] = '{1'b1, 5'd6, 26'h6,       4'h0, 1'b0, 1'b0,  1'b1, 26'h4, 5'd4, 4'h0, 1'b1,  1'b0, 4'h8, 5'd7, 1'b0, 8'd0, 1'b0};
    tbl[17] = '{1'b0, 5'd0, 26'h0,       4'h0, 1'b1, 1'b0,  1'b1, 26'h5, 5'd5, 4'h0, 1'b1,  1'b0, 4'h8, 5'd7, 1'b0, 8'd0, 1'b0};
    tbl[18] = '{1'b0, 5'd0, 26'h0,       4'h0, 1'b1, 1'b0,  1'b1, 26'h6, 5'd6, 4'h0, 1'b0,  1'b0, 4'h8, 5'd7, 1'b0, 8'd0, 1'b0};
    tbl[19] = '{1'b0, 5'd0, 26'h0,       4'h0, 1'b1, 1'b0,  1'b0, 26'h0, 5'd0, 4'h0, 1'b0,  1'b0, 4'h8, 5'd7, 1'b0, 8'd0, 1'b0};

    v = '0;
    arst = 1'b1;
    drive(v);
    #12;
    chk_all_zero("reset", -1);
    arst = 1'b0;
    @(posedge rclk);
    #1;

    for (int i = 0; i < 20; i++) begin
      run_vec(tbl[i], i, 1'b1);
    end

    // Saturation: 260 erroring entries, acked as they appear.
    for (int i = 0; i < 260; i++) begin
      v = '0;
      v.vld  = 1'b1;
      v.tid  = 5'(i);
      v.data = 26'(i);
      v.syn  = 4'h2;
      v.ack  = 1'b1;
      run_vec(v, 100 + i, 1'b0);
    end
    run_vec('{1'b0, 5'd0, 26'h0, 4'h2, 1'b1, 1'b0,  1'b1, 26'h103, 5'd3, 4'h2, 1'b0,  1'b1, 4'h2, 5'd0, 1'b1, 8'd255, 1'b0}, 400, 1'b1);
    // err_clr together with an erroring C9: new error wins.
    run_vec('{1'b1, 5'h11, 26'h111, 4'h0, 1'b1, 1'b0,  1'b0, 26'h0, 5'd0, 4'h0, 1'b0,  1'b1, 4'h2, 5'd0, 1'b1, 8'd255, 1'b0}, 401, 1'b1);
    run_vec('{1'b0, 5'd0, 26'h0, 4'h3, 1'b0, 1'b1,  1'b1, 26'h111, 5'h11, 4'h3, 1'b0,  1'b1, 4'h3, 5'h11, 1'b0, 8'd1, 1'b0}, 402, 1'b1);
    run_vec('{1'b0, 5'd0, 26'h0, 4'h0, 1'b1, 1'b0,  1'b0, 26'h0, 5'd0, 4'h0, 1'b0,  1'b1, 4'h3, 5'h11, 1'b0, 8'd1, 1'b0}, 403, 1'b1);

    // Reset mid-flight with pend_c9=1 and count=1.
    run_vec('{1'b1, 5'd2, 26'hABC, 4'h0, 1'b0, 1'b0,  1'b0, 26'h0, 5'd0, 4'h0, 1'b0,  1'b1, 4'h3, 5'h11, 1'b0, 8'd1, 1'b0}, 500, 1'b1);
    run_vec('{1'b1, 5'd3, 26'hDEF, 4'h0, 1'b0, 1'b0,  1'b1, 26'hABC, 5'd2, 4'h0, 1'b1,  1'b1, 4'h3, 5'h11, 1'b0, 8'd1, 1'b0}, 501, 1'b1);
    v = '0;
    drive(v);
    arst = 1'b1;
    #2;
    chk_all_zero("midreset", 502);
    #4;
    arst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_vec('0, 510 + i, 1'b1);
    end
    run_vec('{1'b1, 5'h1F, 26'h3AB_CDEF, 4'h0, 1'b0, 1'b0,  1'b0, 26'h0, 5'd0, 4'h0, 1'b0,  1'b0, 4'h0, 5'd0, 1'b0, 8'd0, 1'b0}, 520, 1'b1);
    run_vec('{1'b0, 5'd0, 26'h0, 4'h0, 1'b0, 1'b0,  1'b1, 26'h3AB_CDEF, 5'h1F, 4'h0, 1'b0,  1'b0, 4'h0, 5'd0, 1'b0, 8'd0, 1'b0}, 521, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
